// File: rtl/wb_commit_unit.sv
// Writeback commit stage: drives the GPR write port and the NZCV flag write from MEM/WB.
// Dual-destination entries are split over two cycles, and each entry emits one commit record.
module wb_commit_unit #(
  parameter int XLEN      = 64,
  parameter int REG_IDX_W = 5,
  parameter int PC_W      = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [31:0]          in_instr,
  input  logic                 in_wen0,
  input  logic [REG_IDX_W-1:0] in_dst0,
  input  logic [XLEN-1:0]      in_data0,
  input  logic                 in_wen1,
  input  logic [REG_IDX_W-1:0] in_dst1,
  input  logic [XLEN-1:0]      in_data1,
  input  logic                 in_nzcv_en,
  input  logic [3:0]           in_nzcv,
  output logic                 rf_wen,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 nzcv_wen,
  output logic [3:0]           nzcv_wdata,
  output logic                 commit_valid,
  output logic [PC_W-1:0]      commit_pc,
  output logic [31:0]          commit_instr,
  output logic [63:0]          retired_cnt
);

  typedef enum logic {IDLE, DUAL2} state_t;

  localparam logic [REG_IDX_W-1:0] XZR = '1;

  state_t                 state;
  logic                   accept;
  logic                   we0, we1;
  logic                   sameDst, isDual, useSlot0;

  logic [REG_IDX_W-1:0]   holdDst_p1;
  logic [XLEN-1:0]        holdData_p1;
  logic [PC_W-1:0]        holdPc_p1;
  logic [31:0]            holdInstr_p1;
  logic                   holdNzcvEn_p1;
  logic [3:0]             holdNzcv_p1;

  // in_ready depends only on registered state and reset, never on in_valid.
  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // XZR writes are dropped; a same-destination pair collapses to the slot-1 write.
  assign we0      = in_wen0 && (in_dst0 != XZR);
  assign we1      = in_wen1 && (in_dst1 != XZR);
  assign sameDst  = in_dst0 == in_dst1;
  assign isDual   = we0 && we1 && !sameDst;
  assign useSlot0 = we0 && !(we1 && sameDst);

  // ---- Stage p1: registered write port, flag write and commit record ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rf_wen        <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      nzcv_wen      <= 1'b0;
      nzcv_wdata    <= '0;
      commit_valid  <= 1'b0;
      commit_pc     <= '0;
      commit_instr  <= '0;
      retired_cnt   <= '0;
      holdDst_p1    <= '0;
      holdData_p1   <= '0;
      holdPc_p1     <= '0;
      holdInstr_p1  <= '0;
      holdNzcvEn_p1 <= 1'b0;
      holdNzcv_p1   <= '0;
    end else begin
      rf_wen       <= 1'b0;
      nzcv_wen     <= 1'b0;
      commit_valid <= 1'b0;
      retired_cnt  <= retired_cnt + {63'd0, commit_valid};
      case (state)
        IDLE: begin
          if (accept) begin
            rf_wen   <= we0 || we1;
            rf_waddr <= useSlot0 ? in_dst0 : in_dst1;
            rf_wdata <= useSlot0 ? in_data0 : in_data1;
            if (isDual) begin
              state         <= DUAL2;
              holdDst_p1    <= in_dst1;
              holdData_p1   <= in_data1;
              holdPc_p1     <= in_pc;
              holdInstr_p1  <= in_instr;
              holdNzcvEn_p1 <= in_nzcv_en;
              holdNzcv_p1   <= in_nzcv;
            end else begin
              commit_valid <= 1'b1;
              commit_pc    <= in_pc;
              commit_instr <= in_instr;
              nzcv_wen     <= in_nzcv_en;
              nzcv_wdata   <= in_nzcv;
            end
          end
        end
        DUAL2: begin
          // Second half of a dual entry: slot-1 write, then the entry retires.
          state        <= IDLE;
          rf_wen       <= 1'b1;
          rf_waddr     <= holdDst_p1;
          rf_wdata     <= holdData_p1;
          commit_valid <= 1'b1;
          commit_pc    <= holdPc_p1;
          commit_instr <= holdInstr_p1;
          nzcv_wen     <= holdNzcvEn_p1;
          nzcv_wdata   <= holdNzcv_p1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed scenarios plus a randomized run against an entry-level model
// that lists each entry's surviving register writes and retires it on the last one.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_wen0;
  logic [4:0]  in_dst0;
  logic [63:0] in_data0;
  logic        in_wen1;
  logic [4:0]  in_dst1;
  logic [63:0] in_data1;
  logic        in_nzcv_en;
  logic [3:0]  in_nzcv;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        nzcv_wen;
  logic [3:0]  nzcv_wdata;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [31:0] commit_instr;
  logic [63:0] retired_cnt;

  int          nChecks = 0;
  int          nFail   = 0;
  logic [63:0] expCnt  = 64'd0;

  always #5 clk = ~clk;

  wb_commit_unit #(.XLEN(64), .REG_IDX_W(5), .PC_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_wen0(in_wen0), .in_dst0(in_dst0), .in_data0(in_data0),
    .in_wen1(in_wen1), .in_dst1(in_dst1), .in_data1(in_data1),
    .in_nzcv_en(in_nzcv_en), .in_nzcv(in_nzcv),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .nzcv_wen(nzcv_wen), .nzcv_wdata(nzcv_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .retired_cnt(retired_cnt)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        wen0;
    logic [4:0]  dst0;
    logic [63:0] d0;
    logic        wen1;
    logic [4:0]  dst1;
    logic [63:0] d1;
    logic        nen;
    logic [3:0]  nzcv;
  } entry_t;

  // Output view with fields zeroed where their enable is low (those are don't-care).
  // Layout: [171] wen, [101] nzcv_wen, [96] commit.
  function automatic logic [171:0] canon(input logic w, input logic [4:0] a, input logic [63:0] d,
                                         input logic nw, input logic [3:0] n, input logic c,
                                         input logic [63:0] pc, input logic [31:0] ins);
    canon = {w, w ? a : 5'd0, w ? d : 64'd0, nw, nw ? n : 4'd0,
             c, c ? pc : 64'd0, c ? ins : 32'd0};
  endfunction

  logic [171:0] obs;
  assign obs = canon(rf_wen, rf_waddr, rf_wdata, nzcv_wen, nzcv_wdata,
                     commit_valid, commit_pc, commit_instr);

  localparam logic [171:0] IDLE_VIEW = '0;

  function automatic entry_t mk(input logic [63:0] pc, input logic [31:0] ins,
                                input logic w0, input logic [4:0] a0, input logic [63:0] d0,
                                input logic w1, input logic [4:0] a1, input logic [63:0] d1,
                                input logic ne, input logic [3:0] n);
    mk = '{pc: pc, instr: ins, wen0: w0, dst0: a0, d0: d0, wen1: w1, dst1: a1, d1: d1,
           nen: ne, nzcv: n};
  endfunction

  task automatic put(input entry_t e);
    in_valid = 1'b1;  in_pc = e.pc;      in_instr = e.instr;
    in_wen0 = e.wen0; in_dst0 = e.dst0;  in_data0 = e.d0;
    in_wen1 = e.wen1; in_dst1 = e.dst1;  in_data1 = e.d1;
    in_nzcv_en = e.nen; in_nzcv = e.nzcv;
  endtask

  task automatic idle();
    in_valid = 1'b0;  in_pc = 'x;   in_instr = 'x;
    in_wen0 = 'x; in_dst0 = 'x; in_data0 = 'x;
    in_wen1 = 'x; in_dst1 = 'x; in_data1 = 'x;
    in_nzcv_en = 'x; in_nzcv = 'x;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    put(mk(64'h10, 32'h1, 1'b1, 5'd4, 64'h99, 1'b1, 5'd6, 64'h77, 1'b1, 4'hF));
    tick();
    tick();
    nChecks++;
    if ({rf_wen, rf_waddr, rf_wdata, nzcv_wen, nzcv_wdata, commit_valid, commit_pc,
         commit_instr, retired_cnt, in_ready} !== '0) begin
      nFail++;
      $display("FAIL reset_outputs got wen=%b cv=%b cnt=%0d rdy=%b want all zero",
               rf_wen, commit_valid, retired_cnt, in_ready);
    end
    rst = 1'b0;
    idle();
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFail++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
    expCnt = 64'd0;
  endtask

  task automatic test_add();
    entry_t e;
    logic [171:0] want;
    e = mk(64'h8000_0000, 32'h8B02_0023, 1'b1, 5'd3, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b0, 4'h0);
    put(e);
    tick();
    want = canon(1'b1, 5'd3, 64'h1234, 1'b0, 4'h0, 1'b1, 64'h8000_0000, 32'h8B02_0023);
    nChecks++;
    if (obs !== want) begin
      nFail++;
      $display("FAIL add_write got %h want %h", obs, want);
    end
    idle();
    tick();
    nChecks++;
    if ({obs, retired_cnt} !== {IDLE_VIEW, expCnt + 64'd1}) begin
      nFail++;
      $display("FAIL add_count got view=%h cnt=%0d want idle cnt=%0d", obs, retired_cnt, expCnt + 1);
    end
    expCnt = expCnt + 64'd1;
  endtask

  task automatic test_ldp_back_to_back();
    entry_t ldp, add;
    logic [171:0] want;
    ldp = mk(64'h8000_0004, 32'hA940_8BE1, 1'b1, 5'd1, 64'hAA, 1'b1, 5'd2, 64'hBB, 1'b0, 4'h0);
    add = mk(64'h8000_0008, 32'h8B02_0024, 1'b1, 5'd4, 64'h55, 1'b0, 5'd9, 64'd0, 1'b0, 4'h0);
    put(ldp);
    tick();
    want = canon(1'b1, 5'd1, 64'hAA, 1'b0, 4'h0, 1'b0, 64'd0, 32'd0);
    nChecks++;
    if ({obs, in_ready} !== {want, 1'b0}) begin
      nFail++;
      $display("FAIL ldp_first got %h rdy=%b want %h rdy=0", obs, in_ready, want);
    end
    put(add);
    tick();
    want = canon(1'b1, 5'd2, 64'hBB, 1'b0, 4'h0, 1'b1, ldp.pc, ldp.instr);
    nChecks++;
    if ({obs, in_ready} !== {want, 1'b1}) begin
      nFail++;
      $display("FAIL ldp_second got %h rdy=%b want %h rdy=1", obs, in_ready, want);
    end
    tick();
    idle();
    want = canon(1'b1, 5'd4, 64'h55, 1'b0, 4'h0, 1'b1, add.pc, add.instr);
    nChecks++;
    if ({obs, retired_cnt} !== {want, expCnt + 64'd1}) begin
      nFail++;
      $display("FAIL ldp_add_follow got %h cnt=%0d want %h cnt=%0d", obs, retired_cnt, want, expCnt + 1);
    end
    tick();
    nChecks++;
    if ({obs, retired_cnt} !== {IDLE_VIEW, expCnt + 64'd2}) begin
      nFail++;
      $display("FAIL ldp_count got cnt=%0d want %0d", retired_cnt, expCnt + 2);
    end
    expCnt = expCnt + 64'd2;
  endtask

  task automatic test_xzr();
    entry_t a, b;
    logic [171:0] want;
    a = mk(64'h9000, 32'hAA00_001F, 1'b1, 5'd31, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b0, 4'h0);
    b = mk(64'h9004, 32'hF840_0C25, 1'b1, 5'd31, 64'hBEEF, 1'b1, 5'd5, 64'h5555, 1'b0, 4'h0);
    put(a);
    tick();
    want = canon(1'b0, 5'd0, 64'd0, 1'b0, 4'h0, 1'b1, a.pc, a.instr);
    nChecks++;
    if (obs !== want) begin
      nFail++;
      $display("FAIL xzr_dropped got %h want %h", obs, want);
    end
    put(b);
    tick();
    want = canon(1'b1, 5'd5, 64'h5555, 1'b0, 4'h0, 1'b1, b.pc, b.instr);
    nChecks++;
    if ({obs, in_ready} !== {want, 1'b1}) begin
      nFail++;
      $display("FAIL xzr_single got %h rdy=%b want %h rdy=1", obs, in_ready, want);
    end
    idle();
    tick();
    nChecks++;
    if ({obs, retired_cnt} !== {IDLE_VIEW, expCnt + 64'd2}) begin
      nFail++;
      $display("FAIL xzr_count got view=%h cnt=%0d want idle cnt=%0d", obs, retired_cnt, expCnt + 2);
    end
    expCnt = expCnt + 64'd2;
  endtask

  task automatic test_same_dst();
    entry_t e;
    logic [171:0] want;
    e = mk(64'hA000, 32'hA940_1C27, 1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 64'd2, 1'b0, 4'h0);
    put(e);
    tick();
    idle();
    want = canon(1'b1, 5'd7, 64'd2, 1'b0, 4'h0, 1'b1, e.pc, e.instr);
    nChecks++;
    if ({obs, in_ready} !== {want, 1'b1}) begin
      nFail++;
      $display("FAIL same_dst_write got %h rdy=%b want %h rdy=1", obs, in_ready, want);
    end
    tick();
    nChecks++;
    if ({obs, retired_cnt} !== {IDLE_VIEW, expCnt + 64'd1}) begin
      nFail++;
      $display("FAIL same_dst_no_second got view=%h cnt=%0d want idle cnt=%0d", obs, retired_cnt, expCnt + 1);
    end
    expCnt = expCnt + 64'd1;
  endtask

  task automatic test_cmp();
    entry_t e;
    logic [171:0] want;
    e = mk(64'hB000, 32'hEB02_003F, 1'b0, 5'd1, 64'd0, 1'b0, 5'd2, 64'd0, 1'b1, 4'b0110);
    put(e);
    tick();
    idle();
    want = canon(1'b0, 5'd0, 64'd0, 1'b1, 4'b0110, 1'b1, e.pc, e.instr);
    nChecks++;
    if (obs !== want) begin
      nFail++;
      $display("FAIL cmp_flags got %h want %h", obs, want);
    end
    tick();
    nChecks++;
    if ({obs, retired_cnt} !== {IDLE_VIEW, expCnt + 64'd1}) begin
      nFail++;
      $display("FAIL cmp_count got cnt=%0d want %0d", retired_cnt, expCnt + 1);
    end
    expCnt = expCnt + 64'd1;
  endtask

  task automatic test_reset_mid_dual();
    entry_t ldp, add;
    logic [171:0] want;
    // Start from a fresh reset so the count before and after the aborted entry is 0.
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    expCnt = 64'd0;
    ldp = mk(64'hC000, 32'hA940_2D4A, 1'b1, 5'd10, 64'h1010, 1'b1, 5'd11, 64'h1111, 1'b1, 4'h9);
    add = mk(64'hC004, 32'h8B02_002C, 1'b1, 5'd12, 64'h1212, 1'b0, 5'd0, 64'd0, 1'b0, 4'h0);
    put(ldp);
    tick();
    want = canon(1'b1, 5'd10, 64'h1010, 1'b0, 4'h0, 1'b0, 64'd0, 32'd0);
    nChecks++;
    if ({obs, in_ready} !== {want, 1'b0}) begin
      nFail++;
      $display("FAIL mid_dual_first got %h rdy=%b want %h rdy=0", obs, in_ready, want);
    end
    rst = 1'b1;
    idle();
    tick();
    nChecks++;
    if ({obs, retired_cnt} !== {IDLE_VIEW, 64'd0}) begin
      nFail++;
      $display("FAIL mid_dual_discard got %h cnt=%0d want idle cnt=0", obs, retired_cnt);
    end
    rst = 1'b0;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) begin
      nFail++;
      $display("FAIL mid_dual_ready got %b want 1", in_ready);
    end
    put(add);
    tick();
    idle();
    want = canon(1'b1, 5'd12, 64'h1212, 1'b0, 4'h0, 1'b1, add.pc, add.instr);
    nChecks++;
    if ({obs, retired_cnt} !== {want, 64'd0}) begin
      nFail++;
      $display("FAIL mid_dual_next got %h cnt=%0d want %h cnt=0", obs, retired_cnt, want);
    end
    tick();
    nChecks++;
    if (retired_cnt !== 64'd1) begin
      nFail++;
      $display("FAIL mid_dual_count got %0d want 1", retired_cnt);
    end
    expCnt = 64'd1;
  endtask

  function automatic entry_t randEntry();
    entry_t e;
    e.pc    = {$urandom, $urandom};
    e.instr = $urandom;
    e.wen0  = 1'($urandom_range(0, 1));
    e.wen1  = 1'($urandom_range(0, 1));
    e.dst0  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
    e.dst1  = ($urandom_range(0, 3) == 0) ? e.dst0 : 5'($urandom_range(0, 31));
    e.d0    = {$urandom, $urandom};
    e.d1    = {$urandom, $urandom};
    e.nen   = 1'($urandom_range(0, 1));
    e.nzcv  = 4'($urandom_range(0, 15));
    return e;
  endfunction

  task automatic test_random();
    logic [171:0] pendQ[$];
    logic [4:0]   wd[$];
    logic [63:0]  wv[$];
    logic [171:0] want;
    entry_t       e;
    logic         v, hold, stall, accept, last;
    hold  = 1'b0;
    stall = 1'b0;
    v     = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!hold) begin
        if ($urandom_range(0, 9) < 7) begin
          e = randEntry();
          put(e);
          v = 1'b1;
        end else begin
          idle();
          v = 1'b0;
        end
      end
      accept = v && !stall;
      hold   = v && !accept;
      if (accept) begin
        // Surviving writes in order; a repeated destination keeps the later value.
        wd.delete();
        wv.delete();
        if (e.wen0 && e.dst0 != 5'd31) begin
          wd.push_back(e.dst0);
          wv.push_back(e.d0);
        end
        if (e.wen1 && e.dst1 != 5'd31) begin
          if (wd.size() != 0 && wd[0] == e.dst1) wv[0] = e.d1;
          else begin
            wd.push_back(e.dst1);
            wv.push_back(e.d1);
          end
        end
        if (wd.size() == 0)
          pendQ.push_back(canon(1'b0, 5'd0, 64'd0, e.nen, e.nzcv, 1'b1, e.pc, e.instr));
        for (int i = 0; i < wd.size(); i++) begin
          last = (i == wd.size() - 1);
          pendQ.push_back(canon(1'b1, wd[i], wv[i], last & e.nen, e.nzcv, last, e.pc, e.instr));
        end
      end
      tick();
      stall = accept && (wd.size() == 2);
      want  = (pendQ.size() != 0) ? pendQ.pop_front() : IDLE_VIEW;
      nChecks++;
      if ({obs, in_ready, retired_cnt} !== {want, !stall, expCnt}) begin
        nFail++;
        $display("FAIL rand_cycle%0d got %h rdy=%b cnt=%0d want %h rdy=%b cnt=%0d",
                 cyc, obs, in_ready, retired_cnt, want, !stall, expCnt);
      end
      nChecks++;
      if ($isunknown({rf_wen, rf_waddr, rf_wdata, nzcv_wen, nzcv_wdata, commit_valid,
                      commit_pc, commit_instr, retired_cnt})) begin
        nFail++;
        $display("FAIL rand_unknown%0d got X on outputs want known", cyc);
      end
      if (want[96]) expCnt = expCnt + 64'd1;
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_add();
    test_ldp_back_to_back();
    test_xzr();
    test_same_dst();
    test_cmp();
    test_reset_mid_dual();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
